// File: rtl/chime_scheduler.sv
// rtl/chime_scheduler.sv - hourly chime and alarm strike sequencer driving a tone generator
module chime_scheduler #(
    parameter int GAP_CYCLES  = 25000000,
    parameter int ACK_TIMEOUT = 16,
    parameter int ALARM_MAX   = 30
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic       tick_1hz,
    input  logic       chime_en,
    input  logic       alarm_hit,
    input  logic       alarm_stop,
    input  logic       snd_busy,
    output logic       play_sound,
    output logic [1:0] src,
    output logic [5:0] strikes_left
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [AW-1:0] ACK_LAST   = AW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [5:0]    ALARM_LOAD = 6'(ALARM_MAX);

    localparam logic [1:0] SRC_NONE  = 2'b00;
    localparam logic [1:0] SRC_HOUR  = 2'b01;
    localparam logic [1:0] SRC_ALARM = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FIRE       = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_DONE  = 3'd3,
        S_GAP        = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          alarm_pend;
    logic          hour_pend;
    logic [5:0]    hour_strikes;
    logic [GW-1:0] gap_cnt;
    logic [AW-1:0] ack_cnt;
    logic          load_alarm;
    logic          load_hour;

    logic       alarm_active;
    logic       stop_now;
    logic       alarm_req;
    logic       hour_req;
    logic [4:0] h12;
    logic [5:0] hour_load;
    logic       gap_done;
    logic       ack_done;

    assign alarm_active = (src == SRC_ALARM);
    assign stop_now     = alarm_stop && alarm_active;
    assign alarm_req    = alarm_hit && !alarm_active;
    assign hour_req     = tick_1hz && chime_en && (minute == 6'd0) && (second == 6'd0);
    assign h12          = (hour >= 5'd12) ? hour - 5'd12 : hour;
    assign hour_load    = (h12 == 5'd0) ? 6'd12 : {1'b0, h12};
    assign gap_done     = (gap_cnt == GAP_LAST);
    assign ack_done     = (ack_cnt == ACK_LAST);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A pending alarm pre-empts an hourly run only at the end of a gap, so a strike is never cut.
    always_comb begin
        state_nxt  = state;
        load_alarm = 1'b0;
        load_hour  = 1'b0;
        case (state)
            S_IDLE: begin
                if (alarm_pend) begin
                    state_nxt  = S_FIRE;
                    load_alarm = 1'b1;
                end else if (hour_pend) begin
                    state_nxt = S_FIRE;
                    load_hour = 1'b1;
                end
            end
            S_FIRE: begin
                if (strikes_left == 6'd0 || stop_now) begin
                    state_nxt = S_IDLE;
                end else if (!snd_busy) begin
                    state_nxt = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (snd_busy || ack_done) begin
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!snd_busy) begin
                    state_nxt = (strikes_left == 6'd0 || stop_now) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (stop_now) begin
                    state_nxt = S_IDLE;
                end else if (gap_done) begin
                    if (alarm_pend) begin
                        state_nxt  = S_FIRE;
                        load_alarm = 1'b1;
                    end else if (strikes_left != 6'd0) begin
                        state_nxt = S_FIRE;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        play_sound = (state == S_FIRE) && !snd_busy && (strikes_left != 6'd0) && !stop_now;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            alarm_pend   <= 1'b0;
            hour_pend    <= 1'b0;
            hour_strikes <= 6'd0;
            strikes_left <= 6'd0;
            src          <= SRC_NONE;
            gap_cnt      <= '0;
            ack_cnt      <= '0;
        end else begin
            if (load_alarm) begin
                alarm_pend <= 1'b0;
            end else if (alarm_req) begin
                alarm_pend <= 1'b1;
            end

            if (load_hour || load_alarm) begin
                hour_pend <= 1'b0;
            end
            if (hour_req && !alarm_active && !load_alarm) begin
                hour_pend    <= 1'b1;
                hour_strikes <= hour_load;
            end
            if (alarm_req) begin
                hour_pend <= 1'b0;
            end

            if (load_alarm) begin
                strikes_left <= ALARM_LOAD;
                src          <= SRC_ALARM;
            end else if (load_hour) begin
                strikes_left <= hour_strikes;
                src          <= SRC_HOUR;
            end else if (stop_now) begin
                strikes_left <= 6'd0;
            end else if (state == S_WAIT_DONE && !snd_busy && strikes_left != 6'd0) begin
                strikes_left <= strikes_left - 6'd1;
            end
            if (state_nxt == S_IDLE) begin
                strikes_left <= 6'd0;
                src          <= SRC_NONE;
            end

            gap_cnt <= (state == S_GAP && state_nxt == S_GAP) ? gap_cnt + 1'b1 : '0;
            ack_cnt <= (state == S_WAIT_START && state_nxt == S_WAIT_START) ? ack_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_chime_scheduler.sv
// tb/tb_chime_scheduler.sv - self-checking bench for chime_scheduler with a tone generator model
module tb_chime_scheduler;
    localparam int GAP  = 50;
    localparam int ACK  = 16;
    localparam int AMAX = 8;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N = 1'b0;
    logic [4:0] hour = '0;
    logic [5:0] minute = '0;
    logic [5:0] second = '0;
    logic       tick_1hz = 1'b0;
    logic       chime_en = 1'b0;
    logic       alarm_hit = 1'b0;
    logic       alarm_stop = 1'b0;
    logic       snd_busy = 1'b0;
    logic       play_sound;
    logic [1:0] src;
    logic [5:0] strikes_left;

    always #10 CLOCK_50 = ~CLOCK_50;

    chime_scheduler #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK), .ALARM_MAX(AMAX)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .hour(hour), .minute(minute), .second(second),
        .tick_1hz(tick_1hz), .chime_en(chime_en), .alarm_hit(alarm_hit), .alarm_stop(alarm_stop),
        .snd_busy(snd_busy), .play_sound(play_sound), .src(src), .strikes_left(strikes_left)
    );

    int total = 0;
    int bad = 0;

    // tone generator model and pulse monitor; only this process writes these
    int cyc = 0, n_hour = 0, n_alarm = 0, n_other = 0, n_viol = 0, last_pulse = 0;
    int intervals[$];
    int flush_seen = 0, busy_cnt = 0, dly_cnt = 0;
    bit pend = 0;
    // written only by the main sequence
    int tone_len = 20, tone_delay = 0, flush_req = 0;

    initial forever begin
        @(negedge CLOCK_50);
        cyc++;
        if (flush_req != flush_seen) begin
            flush_seen = flush_req;
            busy_cnt = 0;
            pend = 0;
            snd_busy = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) snd_busy = 1'b0;
        end else if (pend) begin
            if (dly_cnt == 0) begin
                pend = 0;
                if (tone_len > 0) begin
                    snd_busy = 1'b1;
                    busy_cnt = tone_len;
                end
            end else begin
                dly_cnt--;
            end
        end
        #1;
        if (play_sound) begin
            if (src == 2'b01) n_hour++;
            else if (src == 2'b10) n_alarm++;
            else n_other++;
            if (snd_busy) n_viol++;
            intervals.push_back(cyc - last_pulse);
            last_pulse = cyc;
            pend = 1;
            dly_cnt = tone_delay;
        end
    end

    initial begin
        #(90000 * 20);
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1);
    end

    typedef struct {
        int h; int m; int s; int en; int al; int blen; int dly; int exp_h; int exp_a;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        RESET_N = 1'b0;
        alarm_stop = 1'b0;
        alarm_hit = 1'b0;
        tick_1hz = 1'b0;
        flush_req++;
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic fire_event(input int h, input int m, input int s, input int en, input int al);
        @(negedge CLOCK_50);
        hour = 5'(h);
        minute = 6'(m);
        second = 6'(s);
        chime_en = en[0];
        tick_1hz = 1'b1;
        alarm_hit = al[0];
        @(negedge CLOCK_50);
        tick_1hz = 1'b0;
        alarm_hit = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int b = 0;
        repeat (3) @(negedge CLOCK_50);
        while (src != 2'b00 && b < 30000) begin
            @(negedge CLOCK_50);
            b++;
        end
        if (b >= 30000) chk({name, "_timeout"}, 1, 0);
        repeat (150) @(negedge CLOCK_50);
    endtask

    task automatic run_case(input vec_t v, input string name);
        int bh, ba;
        do_reset();
        tone_len = v.blen;
        tone_delay = v.dly;
        bh = n_hour;
        ba = n_alarm;
        fire_event(v.h, v.m, v.s, v.en, v.al);
        wait_idle(name);
        chk({name, "_hourly"}, n_hour - bh, v.exp_h);
        chk({name, "_alarm"}, n_alarm - ba, v.exp_a);
        chk({name, "_idle"}, int'({src, strikes_left}), 0);
    endtask

    // Reference: alarm wins outright; otherwise a top-of-hour tick gives hour mod 12 (0 -> 12).
    function automatic int model_hour(input int h, input int m, input int s, input int en, input int al);
        if (al != 0) return 0;
        if (en != 0 && m == 0 && s == 0) return (h % 12 == 0) ? 12 : h % 12;
        return 0;
    endfunction

    vec_t vt[9];

    initial begin
        int bh, ba, b;
        vec_t rv;
        vt[0] = '{15, 0, 0, 1, 0, 100, 0, 3, 0};
        vt[1] = '{0, 0, 0, 1, 0, 20, 1, 12, 0};
        vt[2] = '{12, 0, 0, 1, 0, 20, 2, 12, 0};
        vt[3] = '{15, 0, 0, 0, 0, 20, 0, 0, 0};
        vt[4] = '{15, 1, 0, 1, 0, 20, 0, 0, 0};
        vt[5] = '{7, 0, 5, 1, 0, 20, 0, 0, 0};
        vt[6] = '{23, 0, 0, 1, 0, 10, 3, 11, 0};
        vt[7] = '{13, 0, 0, 1, 1, 10, 0, 0, AMAX};
        vt[8] = '{4, 0, 0, 1, 0, 0, 0, 4, 0};

        repeat (2) @(negedge CLOCK_50);
        chk("reset_play", int'(play_sound), 0);
        chk("reset_src", int'(src), 0);
        chk("reset_strikes", int'(strikes_left), 0);

        for (int i = 0; i < 9; i++) run_case(vt[i], $sformatf("vec%0d", i));

        // busy never rises: every strike is trigger + ACK wait + done cycle + gap apart
        for (int k = 1; k <= 3; k++)
            chk($sformatf("ack_timeout_spacing%0d", k), intervals[intervals.size() - k], ACK + GAP + 2);

        // simultaneous alarm and top-of-hour
        do_reset();
        tone_len = 10;
        fire_event(13, 0, 0, 1, 1);
        @(negedge CLOCK_50);
        chk("simul_src", int'(src), 2);
        chk("simul_strikes", int'(strikes_left), AMAX);
        wait_idle("simul");

        // alarm during hourly strike 2: hourly run cut after that strike
        do_reset();
        tone_len = 30;
        tone_delay = 0;
        bh = n_hour;
        ba = n_alarm;
        fire_event(5, 0, 0, 1, 0);
        b = 0;
        while (n_hour - bh < 2 && b < 5000) begin @(negedge CLOCK_50); b++; end
        b = 0;
        while (!snd_busy && b < 100) begin @(negedge CLOCK_50); b++; end
        alarm_hit = 1'b1;
        @(negedge CLOCK_50);
        alarm_hit = 1'b0;
        wait_idle("preempt");
        chk("preempt_hourly", n_hour - bh, 2);
        chk("preempt_alarm", n_alarm - ba, AMAX);

        // alarm_stop during alarm strike 4
        do_reset();
        tone_len = 60;
        ba = n_alarm;
        fire_event(9, 30, 0, 1, 1);
        b = 0;
        while (n_alarm - ba < 4 && b < 5000) begin @(negedge CLOCK_50); b++; end
        chk("stop_reach4", n_alarm - ba, 4);
        b = 0;
        while (!snd_busy && b < 100) begin @(negedge CLOCK_50); b++; end
        repeat (5) @(negedge CLOCK_50);
        alarm_hit = 1'b1;
        @(negedge CLOCK_50);
        alarm_hit = 1'b0;
        chk("rehit_no_reload", int'(strikes_left), AMAX - 3);
        alarm_stop = 1'b1;
        @(negedge CLOCK_50);
        alarm_stop = 1'b0;
        chk("stop_strikes", int'(strikes_left), 0);
        chk("stop_src_held", int'(src), 2);
        b = 0;
        while (src != 2'b00 && b < 500) begin @(negedge CLOCK_50); b++; end
        chk("stop_busy_at_idle", int'(snd_busy), 0);
        repeat (200) @(negedge CLOCK_50);
        chk("stop_pulses", n_alarm - ba, 4);

        // reset during the gap after hourly strike 2
        do_reset();
        tone_len = 20;
        bh = n_hour;
        fire_event(3, 0, 0, 1, 0);
        b = 0;
        while (n_hour - bh < 2 && b < 5000) begin @(negedge CLOCK_50); b++; end
        b = 0;
        while (!snd_busy && b < 100) begin @(negedge CLOCK_50); b++; end
        b = 0;
        while (snd_busy && b < 100) begin @(negedge CLOCK_50); b++; end
        repeat (5) @(negedge CLOCK_50);
        RESET_N = 1'b0;
        #1;
        chk("rst_play", int'(play_sound), 0);
        chk("rst_src", int'(src), 0);
        chk("rst_strikes", int'(strikes_left), 0);
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (300) @(negedge CLOCK_50);
        chk("rst_no_more_pulses", n_hour - bh, 2);

        for (int r = 0; r < 6; r++) begin
            rv.h = $urandom_range(0, 23);
            rv.m = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 59) : 0;
            rv.s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 59) : 0;
            rv.en = ($urandom_range(0, 3) != 0) ? 1 : 0;
            rv.al = ($urandom_range(0, 3) == 0) ? 1 : 0;
            rv.blen = $urandom_range(5, 40);
            rv.dly = $urandom_range(0, 3);
            rv.exp_h = model_hour(rv.h, rv.m, rv.s, rv.en, rv.al);
            rv.exp_a = (rv.al != 0) ? AMAX : 0;
            run_case(rv, $sformatf("rand%0d", r));
        end

        chk("busy_overlap", n_viol, 0);
        chk("sourceless_pulse", n_other, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/chime_scheduler.md
CHIME_SCHEDULER -- requirements
Module: chime_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 25000000, meaning the silent cycles between consecutive strikes (0.5 s at 50 MHz).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, meaning the maximum cycles to wait for snd_busy to rise after a trigger.
REQ-003 SHALL have parameter ALARM_MAX, default 30, meaning the maximum alarm strikes per alarm event.
REQ-004 SHALL have port CLOCK_50, input, 1 bit: the single 50 MHz clock; all logic is on its rising edge.
REQ-005 SHALL have port RESET_N, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have ports hour, minute and second: hour is a 5-bit input (binary 0-23); minute and second are 6-bit inputs (binary 0-59).
REQ-007 SHALL have port tick_1hz, input, 1 bit: one-cycle pulse asserted when second updates.
REQ-008 SHALL have port chime_en, input, 1 bit: enables hourly chiming.
REQ-009 SHALL have port alarm_hit, input, 1 bit: one-cycle alarm-match pulse; alarm_stop, input, 1 bit: user cancel, level or pulse.
REQ-010 SHALL have port snd_busy, input, 1 bit: high while the tone generator plays.
REQ-011 SHALL have port play_sound, output, 1 bit: one-cycle trigger pulse to the tone generator.
REQ-012 SHALL have port src, output, 2 bits: active source, 00 none, 01 hourly, 10 alarm.
REQ-013 SHALL have port strikes_left, output, 6 bits: strikes remaining, including the one in progress.

Function
REQ-014 SHALL implement states IDLE, FIRE, WAIT_START, WAIT_DONE and GAP.
REQ-015 SHALL latch an hourly request when tick_1hz=1, minute=0, second=0 and chime_en=1; the strike count is hour mod 12, with a result of 0 mapped to 12.
REQ-016 SHALL latch an alarm request when alarm_hit=1; the strike count is ALARM_MAX.
REQ-017 SHALL give alarm priority: simultaneous alarm and hourly requests start the alarm and discard the hourly request.
REQ-018 SHALL ignore an hourly request latched while src=10.
REQ-019 SHALL, on an alarm request during an hourly sequence, discard the remaining hourly strikes at the next GAP or IDLE boundary and start the alarm, never interrupting WAIT_DONE.
REQ-020 SHALL ignore an alarm_hit while src=10; the strike count is not reloaded.
REQ-021 SHALL move IDLE to FIRE on a pending request, loading strikes_left and src.
REQ-022 SHALL, in FIRE, assert play_sound for exactly one cycle, then go to WAIT_START.
REQ-023 SHALL, in WAIT_START, go to WAIT_DONE on snd_busy=1, or after ACK_TIMEOUT cycles without it, counting that strike as done.
REQ-024 SHALL, in WAIT_DONE, go to GAP when snd_busy=0 and decrement strikes_left by 1.
REQ-025 SHALL, in GAP, count GAP_CYCLES cycles and then go to FIRE if strikes_left>0, otherwise to IDLE with src=00.
REQ-026 SHALL, when alarm_stop=1 during an alarm, set strikes_left to 0 within one cycle and end the sequence.
REQ-027 SHALL apply REQ-026 with no new play_sound pulse and the current sound not cut: the block waits for snd_busy=0, then goes to IDLE without a GAP.
REQ-028 SHALL have alarm_stop take precedence over a same-cycle alarm_hit when src=10.
REQ-029 SHALL hold play_sound low in every state except FIRE and SHALL never assert it while snd_busy=1.
REQ-030 SHALL make the GAP counter wide enough for GAP_CYCLES; strikes_left SHALL never decrement below 0.
REQ-031 SHALL hold strikes_left=0 and src=00 in IDLE.

Reset
REQ-032 SHALL, while RESET_N=0, asynchronously force state IDLE, play_sound=0, src=00, strikes_left=0, all counters 0 and all pending requests cleared.
REQ-033 SHALL, on reset mid-sequence, produce no further play_sound pulses after release until a new request arrives.

Verification
REQ-034 SHALL cover: hour=15, minute=0, second=0, tick_1hz, chime_en=1, model busy 100 cycles, GAP_CYCLES=50 -> exactly 3 play_sound pulses with src=01, then IDLE.
REQ-035 SHALL cover: hour=0 at the top of the hour -> 12 pulses; hour=12 -> 12 pulses; chime_en=0 -> 0 pulses.
REQ-036 SHALL cover: alarm_hit and a top-of-hour tick in the same cycle -> src=10, strikes_left=ALARM_MAX, no hourly strikes.
REQ-037 SHALL cover: alarm_stop during strike 4 of the alarm -> strike 4 completes, no 5th pulse, IDLE after snd_busy falls.
REQ-038 SHALL cover: snd_busy tied to 0 -> each strike ends after ACK_TIMEOUT cycles, the full count is still issued, and the block does not hang.
REQ-039 SHALL cover: RESET_N pulsed low during GAP of the hourly strike 2 -> outputs immediately 0, no pulses after release.
